// File: rtl/stopwatch_core_pkg.sv
// Shared state encodings, digit limits and digit widths for the stopwatch core.
package stopwatch_core_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  localparam int MSEC_MAX = 99;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

endpackage

// File: rtl/stopwatch_core_time_counter.sv
// One wrapping time digit: counts 0..MAX on i_inc, synchronous clear, carry out at MAX.
module time_counter #(
  parameter int WIDTH = 7,
  parameter int MAX   = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_count,
  output logic             o_carry
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Anything at or beyond MAX wraps, so a corrupted value self-heals on the next increment.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_inc) begin
      count_d = (count_q >= MAX_V) ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;
  assign o_carry = i_inc && (count_q == MAX_V);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch time base: 100 Hz divider, STOP/RUN/CLEAR control and msec..hour cascade.
module stopwatch_core
  import stopwatch_core_pkg::*;
#(
  parameter int F_CLK   = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run_stop,
  input  logic              i_clear,
  output logic              o_running,
  output logic [MSEC_W-1:0] msec,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour
);

  localparam int TICK_DIV = F_CLK / TICK_HZ;
  localparam int DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic             running_q, running_d;
  logic [DIV_W-1:0] div_q, div_d;

  logic tick;
  logic clr_cnt;
  logic c_ms, c_s, c_m;
  logic unused_hour_carry;

  assign tick    = (state_q == ST_RUN) && (div_q == DIV_LAST);
  assign clr_cnt = (state_q == ST_CLEAR);

  // Clear has priority over run_stop in STOP; clear is dropped entirely while running.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STOP: begin
        if (i_clear)         state_d = ST_CLEAR;
        else if (i_run_stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_run_stop) state_d = ST_STOP;
      end
      ST_CLEAR: state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
    running_d = (state_d == ST_RUN);
  end

  // Divider only advances in RUN, so a pause keeps the sub-tick phase.
  always_comb begin
    div_d = div_q;
    if (clr_cnt) begin
      div_d = '0;
    end else if (state_q == ST_RUN) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_STOP;
      running_q <= 1'b0;
      div_q     <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      div_q     <= div_d;
    end
  end

  assign o_running = running_q;

  time_counter #(.WIDTH(MSEC_W), .MAX(MSEC_MAX)) u_msec (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (tick),
    .i_clear (clr_cnt),
    .o_count (msec),
    .o_carry (c_ms)
  );

  time_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (c_ms),
    .i_clear (clr_cnt),
    .o_count (sec),
    .o_carry (c_s)
  );

  time_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (c_s),
    .i_clear (clr_cnt),
    .o_count (min),
    .o_carry (c_m)
  );

  // Hours wrap silently; their carry goes nowhere.
  time_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (c_m),
    .i_clear (clr_cnt),
    .o_count (hour),
    .o_carry (unused_hour_carry)
  );

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed steps plus random pulses against a total-hundredths model.
module tb_stopwatch_core;

  logic       clk;
  logic       rst;
  logic       i_run_stop;
  logic       i_clear;
  logic       o_running;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;

  int vectors;
  int miscompares;

  // Reference model: elapsed time as one hundredths total, plus run flag and tick phase.
  int m_total;
  int m_phase;
  bit m_running;
  bit m_clearing;

  localparam int DAY = 24 * 60 * 60 * 100;

  stopwatch_core #(.F_CLK(1000), .TICK_HZ(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_run_stop (i_run_stop),
    .i_clear    (i_clear),
    .o_running  (o_running),
    .msec       (msec),
    .sec        (sec),
    .min        (min),
    .hour       (hour)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_total    = 0;
    m_phase    = 0;
    m_running  = 0;
    m_clearing = 0;
  endtask

  task automatic model_edge(input bit rs, input bit clr);
    if (m_clearing) begin
      m_total    = 0;
      m_phase    = 0;
      m_clearing = 0;
    end else if (m_running) begin
      m_phase++;
      if (m_phase == 10) begin
        m_phase = 0;
        m_total = (m_total + 1) % DAY;
      end
      if (rs) m_running = 0;
    end else if (clr) begin
      m_clearing = 1;
    end else if (rs) begin
      m_running = 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".run"},  32'(o_running), 32'(m_running));
    check({tag, ".msec"}, 32'(msec), 32'(m_total % 100));
    check({tag, ".sec"},  32'(sec),  32'((m_total / 100) % 60));
    check({tag, ".min"},  32'(min),  32'((m_total / 6000) % 60));
    check({tag, ".hour"}, 32'(hour), 32'(m_total / 360000));
  endtask

  // Called at a negedge: drive pulses for one edge, then check at the following negedge.
  task automatic step(input bit rs, input bit clr, input string tag);
    i_run_stop = rs;
    i_clear    = clr;
    @(posedge clk);
    model_edge(rs, clr);
    @(negedge clk);
    i_run_stop = 1'b0;
    i_clear    = 1'b0;
    check_all(tag);
  endtask

  task automatic run_to_phase9(input string tag);
    for (int k = 0; k < 20 && m_phase != 9; k++) step(0, 0, tag);
    check({tag, ".phase_bound"}, 32'(m_phase), 32'd9);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    i_run_stop  = 1'b0;
    i_clear     = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset_held");
    rst = 1'b1;
    @(negedge clk);
    check_all("reset_rel");

    // 1. start and first ticks
    step(1, 0, "t1_start");
    check("t1_running", 32'(o_running), 32'd1);
    for (int k = 0; k < 9; k++) step(0, 0, "t1_wait");
    check("t1_msec_9cyc", 32'(msec), 32'd0);
    step(0, 0, "t1_tick1");
    check("t1_msec_10cyc", 32'(msec), 32'd1);
    for (int k = 0; k < 10; k++) step(0, 0, "t1_tick2");
    check("t1_msec_20cyc", 32'(msec), 32'd2);

    // 2. 1000 ticks, pause mid-phase, resume
    for (int k = 0; k < 9980; k++) step(0, 0, "t2_run");
    check("t2_sec", 32'(sec), 32'd10);
    check("t2_msec", 32'(msec), 32'd0);
    for (int k = 0; k < 4; k++) step(0, 0, "t2_phase");
    step(1, 0, "t2_stop");
    for (int k = 0; k < 50; k++) step(0, 0, "t2_frozen");
    check("t2_frozen_sec", 32'(sec), 32'd10);
    step(1, 0, "t2_resume");
    for (int k = 0; k < 15; k++) step(0, 0, "t2_after");

    // 3. clear from STOP, clear ignored in RUN
    step(1, 0, "t3_stop");
    step(0, 1, "t3_clr0");
    step(0, 0, "t3_clr1");
    step(1, 0, "t3_run");
    for (int k = 0; k < 20000 && m_total != 1234; k++) step(0, 0, "t3_count");
    step(1, 0, "t3_stop2");
    check("t3_sec12", 32'(sec), 32'd12);
    check("t3_msec34", 32'(msec), 32'd34);
    step(0, 1, "t3_clear_e1");
    step(0, 0, "t3_clear_e2");
    check("t3_cleared", 32'(msec), 32'd0);
    step(1, 0, "t3_run2");
    for (int k = 0; k < 25; k++) step(0, 0, "t3_run2");
    step(0, 1, "t3_clr_in_run");
    check("t3_run_kept", 32'(o_running), 32'd1);
    for (int k = 0; k < 12; k++) step(0, 0, "t3_after");

    // 4. full rollover from a preloaded 23:59:59.99
    step(1, 0, "t4_stop");
    step(0, 1, "t4_clr");
    step(0, 0, "t4_clr2");
    dut.u_msec.count_q = 7'd99;
    dut.u_sec.count_q  = 6'd59;
    dut.u_min.count_q  = 6'd59;
    dut.u_hour.count_q = 5'd23;
    m_total = DAY - 1;
    #1;
    check_all("t4_preload");
    step(1, 0, "t4_run");
    run_to_phase9("t4_wait");
    check("t4_tick", 32'(dut.tick), 32'd1);
    check("t4_c_ms", 32'(dut.c_ms), 32'd1);
    check("t4_c_s", 32'(dut.c_s), 32'd1);
    check("t4_c_m", 32'(dut.c_m), 32'd1);
    check("t4_c_h", 32'(dut.u_hour.o_carry), 32'd1);
    step(0, 0, "t4_roll");
    check("t4_roll_hour", 32'(hour), 32'd0);
    check("t4_roll_msec", 32'(msec), 32'd0);

    // 5. simultaneous pulses in STOP; stop coincident with tick
    step(1, 0, "t5_stop");
    step(1, 1, "t5_both");
    check("t5_both_run", 32'(o_running), 32'd0);
    step(0, 0, "t5_exit_clear");
    step(0, 0, "t5_idle");
    step(1, 0, "t5_run");
    for (int k = 0; k < 23; k++) step(0, 0, "t5_run");
    run_to_phase9("t5_wait");
    step(1, 0, "t5_stop_on_tick");
    check("t5_tick_counted", 32'(msec), 32'd3);
    check("t5_stopped", 32'(o_running), 32'd0);

    // random pulses
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0), "rand");
    end

    // 6. asynchronous reset mid-RUN
    if (!m_running) step(1, 0, "t6_start");
    for (int k = 0; k < 37; k++) step(0, 0, "t6_run");
    @(posedge clk);
    model_edge(0, 0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("t6_async");
    @(negedge clk);
    rst = 1'b1;
    check_all("t6_rel");
    step(0, 0, "t6_stop");
    step(0, 0, "t6_stop2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
